// File: rtl/mips_pkg.sv
// Shared types and width defaults for the pipeline memory path.
package mips_pkg;

   localparam int ADDRESS_WIDTH_DEFAULT = 32;
   localparam int DATA_WIDTH_DEFAULT    = 32;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH_BUSY = 2'd1,
      DATA_BUSY  = 2'd2,
      FETCH_DROP = 2'd3
   } arbiter_state_t;

endpackage

// File: rtl/memory_grant_select.sv
// Priority between fetch and data requests with a bounded data streak so a
// waiting fetch is not starved.
module memory_grant_select
   import mips_pkg::*;
#(
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic idle,
   input  logic fetch_request,
   input  logic fetch_flush,
   input  logic fetch_done,
   input  logic data_request,
   input  logic data_done,
   output logic grant_fetch,
   output logic grant_data
);

   localparam int STREAK_WIDTH = $clog2(DATA_STREAK_MAX + 1);
   localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(DATA_STREAK_MAX);

   logic [STREAK_WIDTH-1:0] data_streak;
   logic                    streak_full;
   logic                    fetch_ok;
   logic                    data_ok;

   assign streak_full = (data_streak == STREAK_MAX);

   // A port whose done pulse is high still shows its old request; ignore it.
   always_comb begin
      fetch_ok    = fetch_request & ~fetch_done & ~fetch_flush;
      data_ok     = data_request & ~data_done;
      grant_fetch = idle & fetch_ok & (~data_ok | streak_full);
      grant_data  = idle & data_ok & ~grant_fetch;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_streak <= '0;
      end else if (!fetch_request || grant_fetch) begin
         data_streak <= '0;
      end else if (grant_data && !streak_full) begin
         data_streak <= data_streak + 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Single-outstanding-transaction arbiter between instruction fetch and data
// accesses on a shared single-port memory.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | no transaction outstanding; arbitrate pending requests
//   FETCH_BUSY | fetch issued, waiting for mem_ready
//   DATA_BUSY  | load/store issued, waiting for mem_ready
//   FETCH_DROP | flushed fetch still in flight; response is discarded
module memory_arbiter
   import mips_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = ADDRESS_WIDTH_DEFAULT,
   parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     fetch_request,
   input  logic [ADDRESS_WIDTH-1:0] fetch_address,
   input  logic                     fetch_flush,
   output logic                     fetch_done,
   output logic [DATA_WIDTH-1:0]    fetch_instruction,
   output logic                     fetch_stall,
   input  logic                     memory_read,
   input  logic                     memory_write,
   input  logic [ADDRESS_WIDTH-1:0] data_address,
   input  logic [DATA_WIDTH-1:0]    data_write_data,
   output logic                     data_done,
   output logic [DATA_WIDTH-1:0]    data_read_data,
   output logic                     data_stall,
   output logic                     mem_valid,
   output logic                     mem_write,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   input  logic [DATA_WIDTH-1:0]    mem_read_data,
   input  logic                     mem_ready
);

   arbiter_state_t state;
   arbiter_state_t state_next;
   logic           grant_fetch;
   logic           grant_data;
   logic           data_request;

   assign data_request = memory_read | memory_write;
   assign fetch_stall  = fetch_request & ~fetch_done;
   assign data_stall   = data_request & ~data_done;

   memory_grant_select #(
      .DATA_STREAK_MAX (DATA_STREAK_MAX)
   ) u_grant_select (
      .clock         (clock),
      .reset         (reset),
      .idle          (state == IDLE),
      .fetch_request (fetch_request),
      .fetch_flush   (fetch_flush),
      .fetch_done    (fetch_done),
      .data_request  (data_request),
      .data_done     (data_done),
      .grant_fetch   (grant_fetch),
      .grant_data    (grant_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_fetch) begin
               state_next = FETCH_BUSY;
            end else if (grant_data) begin
               state_next = DATA_BUSY;
            end
         end
         FETCH_BUSY: begin
            if (mem_ready) begin
               state_next = IDLE;
            end else if (fetch_flush) begin
               state_next = FETCH_DROP;
            end
         end
         DATA_BUSY: begin
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         FETCH_DROP: begin
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_valid         <= 1'b0;
         mem_write         <= 1'b0;
         mem_address       <= '0;
         mem_write_data    <= '0;
         fetch_done        <= 1'b0;
         data_done         <= 1'b0;
         fetch_instruction <= '0;
         data_read_data    <= '0;
      end else begin
         fetch_done <= 1'b0;
         data_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_fetch) begin
                  mem_valid      <= 1'b1;
                  mem_write      <= 1'b0;
                  mem_address    <= fetch_address;
                  mem_write_data <= '0;
               end else if (grant_data) begin
                  mem_valid      <= 1'b1;
                  mem_write      <= memory_write;
                  mem_address    <= data_address;
                  mem_write_data <= data_write_data;
               end
            end
            FETCH_BUSY: begin
               // A flush landing on the completion edge still discards the word.
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (!fetch_flush) begin
                     fetch_done        <= 1'b1;
                     fetch_instruction <= mem_read_data;
                  end
               end
            end
            DATA_BUSY: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  data_done <= 1'b1;
                  if (!mem_write) begin
                     data_read_data <= mem_read_data;
                  end
               end
            end
            FETCH_DROP: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
               end
            end
            default: mem_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, hand-written corner cases,
// and random traffic against a transaction-level reference model.
module tb_memory_arbiter;
   import mips_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          fetch_request, fetch_flush, fetch_done, fetch_stall;
   logic [AW-1:0] fetch_address;
   logic [DW-1:0] fetch_instruction;
   logic          memory_read, memory_write, data_done, data_stall;
   logic [AW-1:0] data_address;
   logic [DW-1:0] data_write_data, data_read_data;
   logic          mem_valid, mem_write, mem_ready;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data, mem_read_data;

   always #5 clock = ~clock;

   memory_arbiter #(
      .ADDRESS_WIDTH   (AW),
      .DATA_WIDTH      (DW),
      .DATA_STREAK_MAX (SMAX)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .fetch_request     (fetch_request),
      .fetch_address     (fetch_address),
      .fetch_flush       (fetch_flush),
      .fetch_done        (fetch_done),
      .fetch_instruction (fetch_instruction),
      .fetch_stall       (fetch_stall),
      .memory_read       (memory_read),
      .memory_write      (memory_write),
      .data_address      (data_address),
      .data_write_data   (data_write_data),
      .data_done         (data_done),
      .data_read_data    (data_read_data),
      .data_stall        (data_stall),
      .mem_valid         (mem_valid),
      .mem_write         (mem_write),
      .mem_address       (mem_address),
      .mem_write_data    (mem_write_data),
      .mem_read_data     (mem_read_data),
      .mem_ready         (mem_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Transaction fields are only compared while a transaction is expected.
   function automatic logic [159:0] obs(input logic mv_ref, input logic mw_ref);
      return {26'd0, mem_valid, mv_ref ? mem_write : 1'b0,
              mv_ref ? mem_address : 32'd0, (mv_ref && mw_ref) ? mem_write_data : 32'd0,
              fetch_done, data_done, fetch_stall, data_stall,
              fetch_instruction, data_read_data};
   endfunction

   function automatic logic [159:0] exp_pack(input logic mv, input logic mw,
         input logic [31:0] ma, input logic [31:0] mwd, input logic fd, input logic dd,
         input logic fs, input logic ds, input logic [31:0] fi, input logic [31:0] drd);
      return {26'd0, mv, mv ? mw : 1'b0, mv ? ma : 32'd0, (mv && mw) ? mwd : 32'd0,
              fd, dd, fs, ds, fi, drd};
   endfunction

   task automatic idle_inputs();
      fetch_request   = 0; fetch_address = 0; fetch_flush = 0;
      memory_read     = 0; memory_write  = 0; data_address = 0;
      data_write_data = 0; mem_ready     = 0; mem_read_data = 0;
   endtask

   // grant order monitor
   logic [31:0] grants[$];
   logic        prev_mv = 1'b0;
   always @(negedge clock) begin
      if (mem_valid && !prev_mv) grants.push_back(mem_address);
      prev_mv = mem_valid;
   end

   typedef struct {
      logic        rst, freq;
      logic [31:0] faddr;
      logic        mrd, mwr;
      logic [31:0] daddr, wdata;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_mv, e_mw;
      logic [31:0] e_ma, e_mwd;
      logic        e_fd, e_dd, e_fs, e_ds;
      logic [31:0] e_fi, e_drd;
   } vec_t;

   typedef struct {
      bit          active, is_fetch, cancelled, wr;
      logic [31:0] addr, wdata;
   } txn_t;

   txn_t        tx;
   int          streak;
   bit          e_fd, e_dd;
   logic [31:0] e_fi, e_drd;

   // One clock of the reference: the inputs now present decide the next outputs.
   task automatic model_step();
      bit f_ok, d_ok, fwin, fd_n, dd_n;
      if (reset) begin
         tx = '{0, 0, 0, 0, 32'd0, 32'd0};
         streak = 0; e_fd = 0; e_dd = 0; e_fi = 0; e_drd = 0;
         return;
      end
      fd_n = 0; dd_n = 0;
      if (tx.active) begin
         if (tx.is_fetch && fetch_flush) tx.cancelled = 1;
         if (mem_ready) begin
            if (tx.is_fetch) begin
               if (!tx.cancelled) begin fd_n = 1; e_fi = mem_read_data; end
            end else begin
               dd_n = 1;
               if (!tx.wr) e_drd = mem_read_data;
            end
            tx.active = 0;
         end
         if (!fetch_request) streak = 0;
      end else begin
         f_ok = fetch_request && !e_fd && !fetch_flush;
         d_ok = (memory_read || memory_write) && !e_dd;
         fwin = f_ok && (!d_ok || streak == SMAX);
         if (fwin) begin
            tx = '{1, 1, 0, 0, fetch_address, 32'd0};
            streak = 0;
         end else if (d_ok) begin
            tx = '{1, 0, 0, memory_write, data_address, data_write_data};
            streak = fetch_request ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
         end else if (!fetch_request) begin
            streak = 0;
         end
      end
      e_fd = fd_n; e_dd = dd_n;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[12];
      logic [31:0] exp_g[4];
      int          g_base, fd_cnt, lat, total_ticks, late;
      bit          data_new, got, f_after, d_after;
      logic [31:0] db, fi;

      db = 32'hDEADBEEF;
      fi = 32'h8C010000;
      vt[0]  = '{1,0,0,    0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,0};
      vt[1]  = '{0,0,0,    1,0,32'h40,0,0,0,                  1,0,32'h40,0,0,0,0,1,0,0};
      vt[2]  = '{0,0,0,    1,0,32'h40,0,0,0,                  1,0,32'h40,0,0,0,0,1,0,0};
      vt[3]  = '{0,0,0,    1,0,32'h40,0,1,db,                 0,0,0,0,0,1,0,0,0,db};
      vt[4]  = '{0,0,0,    1,0,32'h40,0,0,0,                  0,0,0,0,0,0,0,1,0,db};
      vt[5]  = '{0,0,0,    0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,db};
      vt[6]  = '{0,1,32'h100,0,1,32'h200,32'h1234,0,0,         1,1,32'h200,32'h1234,0,0,1,1,0,db};
      vt[7]  = '{0,1,32'h100,0,1,32'h200,32'h1234,1,32'hAAAA5555, 0,0,0,0,0,1,1,0,0,db};
      vt[8]  = '{0,1,32'h100,0,1,32'h200,32'h1234,0,0,         1,0,32'h100,0,0,0,1,1,0,db};
      vt[9]  = '{0,1,32'h100,0,0,0,0,1,fi,                    0,0,0,0,1,0,0,0,fi,db};
      vt[10] = '{0,1,32'h100,0,0,0,0,0,0,                     0,0,0,0,0,0,1,0,fi,db};
      vt[11] = '{0,0,0,    0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,fi,db};

      idle_inputs();
      reset = 1;
      tick();

      // directed table: single load, then store racing a fetch
      for (int i = 0; i < 12; i++) begin
         reset = vt[i].rst; fetch_request = vt[i].freq; fetch_address = vt[i].faddr;
         memory_read = vt[i].mrd; memory_write = vt[i].mwr; data_address = vt[i].daddr;
         data_write_data = vt[i].wdata; mem_ready = vt[i].rdy; mem_read_data = vt[i].rdata;
         tick();
         check($sformatf("vec%0d", i), obs(vt[i].e_mv, vt[i].e_mw),
               exp_pack(vt[i].e_mv, vt[i].e_mw, vt[i].e_ma, vt[i].e_mwd, vt[i].e_fd,
                        vt[i].e_dd, vt[i].e_fs, vt[i].e_ds, vt[i].e_fi, vt[i].e_drd));
      end

      // fairness: redirects in each data-done cycle keep data ahead until the streak cap
      idle_inputs(); reset = 1; tick(); reset = 0;
      g_base = grants.size(); data_new = 0;
      fetch_request = 1; fetch_address = 32'h500; memory_read = 1; data_address = 32'hD00;
      for (int c = 0; c < 40 && (grants.size() - g_base) < 4; c++) begin
         tick();
         mem_ready = mem_valid; mem_read_data = 32'h11110000 + c;
         fetch_flush = 0;
         if (data_new) begin data_address = data_address + 32'h10; data_new = 0; end
         if (data_done) begin fetch_flush = 1; data_new = 1; end
      end
      exp_g = '{32'hD00, 32'hD10, 32'h500, 32'hD20};
      check("fair_count", grants.size() - g_base, 4);
      for (int k = 0; k < 4; k++)
         if (g_base + k < grants.size())
            check($sformatf("fair_grant%0d", k), grants[g_base + k], exp_g[k]);

      // flush of an in-flight fetch
      idle_inputs(); reset = 1; tick(); reset = 0;
      fetch_request = 1; fetch_address = 32'h300; tick();
      check("fl_grant", {mem_valid, mem_address}, {1'b1, 32'h300});
      fetch_flush = 1; tick(); fetch_flush = 0; fd_cnt = int'(fetch_done);
      tick(); fd_cnt += int'(fetch_done);
      mem_ready = 1; mem_read_data = 32'hBAD0BAD0; fetch_address = 32'h400;
      tick(); fd_cnt += int'(fetch_done);
      check("fl_mv_drop", mem_valid, 0);
      mem_ready = 0; tick(); fd_cnt += int'(fetch_done);
      check("fl_no_done", {fd_cnt, fetch_instruction}, 0);
      check("fl_regrant", {mem_valid, mem_address}, {1'b1, 32'h400});
      mem_ready = 1; mem_read_data = 32'h24080004; tick();
      check("fl_done", {fetch_done, fetch_instruction}, {1'b1, 32'h24080004});
      mem_ready = 0; tick(); fetch_request = 0; tick();

      // zero-wait memory, four alternating single requests
      idle_inputs(); mem_ready = 1; total_ticks = 0;
      for (int k = 0; k < 4; k++) begin
         mem_read_data = 32'hC0DE0000 + k;
         if (k % 2 == 0) begin fetch_request = 1; fetch_address = 32'h1000 + k * 4; end
         else begin memory_read = 1; data_address = 32'h2000 + k * 4; end
         lat = 0; got = 0;
         while (!got && lat < 10) begin
            tick(); lat++;
            got = (k % 2 == 0) ? fetch_done : data_done;
         end
         check($sformatf("zw_lat%0d", k), lat, 2);
         check($sformatf("zw_data%0d", k),
               (k % 2 == 0) ? fetch_instruction : data_read_data, 32'hC0DE0000 + k);
         tick(); total_ticks += lat + 1;
         fetch_request = 0; memory_read = 0;
      end
      check("zw_total", total_ticks, 12);

      // reset in the middle of a load
      mem_ready = 0; memory_read = 1; data_address = 32'h80; tick();
      check("rst_pre_mv", mem_valid, 1);
      reset = 1; tick();
      check("rst_outs", {mem_valid, mem_write, mem_address, mem_write_data, fetch_done,
                         data_done, fetch_instruction, data_read_data}, 0);
      check("rst_stall", {fetch_stall, data_stall}, 2'b01);
      reset = 0; memory_read = 0; mem_ready = 1; mem_read_data = 32'h55; late = 0;
      repeat (3) begin tick(); late += int'(data_done | fetch_done | mem_valid); end
      check("rst_late", {late, data_read_data}, 0);
      mem_ready = 0; fetch_request = 1; fetch_address = 32'h90; tick();
      check("rst_idle_grant", {mem_valid, mem_address}, {1'b1, 32'h90});

      // random traffic against the reference model
      f_after = 0; d_after = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
         fetch_flush = 0;
         if (fetch_done) begin
            f_after = 1;
         end else if (f_after || !fetch_request) begin
            f_after = 0;
            if ($urandom_range(0, 2) == 0) begin
               fetch_request = 1; fetch_address = $urandom() & 32'hFFFF_FFFC;
            end else begin
               fetch_request = 0;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            fetch_flush = 1; fetch_address = $urandom() & 32'hFFFF_FFFC;
         end
         if (data_done) begin
            d_after = 1;
         end else if (d_after || !(memory_read || memory_write)) begin
            int r;
            d_after = 0;
            r = int'($urandom_range(0, 3));
            memory_read = (r == 0); memory_write = (r == 1);
            data_address = $urandom() & 32'hFFFF_FFFC; data_write_data = $urandom();
         end
         mem_ready = mem_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
         mem_read_data = $urandom();
         model_step();
         tick();
         check("rand", obs(tx.active, tx.wr),
               exp_pack(tx.active, tx.wr, tx.addr, tx.wdata, e_fd, e_dd,
                        fetch_request & ~e_fd, (memory_read | memory_write) & ~e_dd,
                        e_fi, e_drd));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
